// File: rtl/audio_direction_estimator.sv
// ---------------------------------------------------------------------------
// audio_direction_estimator
//
// Integrates rectified left/right microphone samples over a fixed window of
// 2^WINDOW_LOG2 samples per channel, then turns the L/R level imbalance into a
// direction bit and an 8-bit correction magnitude for servo_interface. A
// result is released only on the servo's frame pulse, so at most one
// correction is issued per servo frame.
//
// Ports
//   clock         system clock
//   reset         synchronous, active-high reset
//   enable        tracking enable; low forces IDLE and clears the window
//   sample_ready  one-cycle strobe, left_in/right_in valid
//   left_in       left mic sample, two's complement
//   right_in      right mic sample, two's complement
//   servo_ready   one-cycle pulse at each servo frame update
//   audio_dir     1 = right louder, 0 = left louder or equal
//   audio_val     correction magnitude 0..255, held until the next emit
//   audio_done    one-cycle strobe, audio_dir/audio_val valid
//   busy          high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module audio_direction_estimator #(
    parameter int WINDOW_LOG2 = 10,
    parameter int GAIN_SHIFT  = 1,
    parameter int DEADBAND    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_ready,
    input  logic signed [7:0] left_in,
    input  logic signed [7:0] right_in,
    input  logic              servo_ready,
    output logic              audio_dir,
    output logic [7:0]        audio_val,
    output logic              audio_done,
    output logic              busy
);

    localparam int ACC_W  = WINDOW_LOG2 + 9;
    localparam int DIFF_W = ACC_W + 1;
    localparam int SCL_W  = DIFF_W + GAIN_SHIFT;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        CALC,
        SCALE,
        WAIT_RDY,
        EMIT
    } state_t;

    state_t                   state;
    logic [ACC_W-1:0]         acc_l;
    logic [ACC_W-1:0]         acc_r;
    logic [WINDOW_LOG2-1:0]   sample_cnt;

    logic signed [DIFF_W-1:0] diff_p1;
    logic                     dir_p1;
    logic [7:0]               val_p2;

    logic signed [DIFF_W-1:0] diff_c;
    logic [DIFF_W-1:0]        mag_c;
    logic [DIFF_W-1:0]        avg_c;
    logic [SCL_W-1:0]         scaled_c;
    logic [7:0]               val_c;

    // 9-bit rectifier: the extra bit lets |-128| be represented as 128.
    function automatic logic [8:0] abs9(input logic signed [7:0] s);
        logic [8:0] ext;
        ext = {s[7], s};
        if (s[7])
            abs9 = 9'(~ext + 9'd1);
        else
            abs9 = ext;
    endfunction

    // The window difference is bounded by 128 * 2^WINDOW_LOG2, so negating the
    // most negative reachable value never overflows DIFF_W bits.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] d);
        if (d[DIFF_W-1])
            abs_diff = DIFF_W'(-d);
        else
            abs_diff = DIFF_W'(d);
    endfunction

    function automatic logic [7:0] sat8(input logic [SCL_W-1:0] x);
        if (x > SCL_W'(255))
            sat8 = 8'hFF;
        else
            sat8 = x[7:0];
    endfunction

    assign diff_c   = $signed({1'b0, acc_r}) - $signed({1'b0, acc_l});
    assign mag_c    = abs_diff(diff_p1);
    assign avg_c    = mag_c >> WINDOW_LOG2;
    assign scaled_c = SCL_W'(avg_c) << GAIN_SHIFT;
    assign val_c    = sat8(scaled_c);

    assign busy       = (state != IDLE);
    // Gated by enable so a strobe can never escape while tracking is off.
    assign audio_done = (state == EMIT) && enable;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            acc_l      <= '0;
            acc_r      <= '0;
            sample_cnt <= '0;
            audio_dir  <= 1'b0;
            audio_val  <= 8'd0;
        end else if (!enable) begin
            state      <= IDLE;
            acc_l      <= '0;
            acc_r      <= '0;
            sample_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= ACCUM;
                    acc_l      <= '0;
                    acc_r      <= '0;
                    sample_cnt <= '0;
                end
                ACCUM: begin
                    if (sample_ready) begin
                        acc_l      <= acc_l + ACC_W'(abs9(left_in));
                        acc_r      <= acc_r + ACC_W'(abs9(right_in));
                        // Counter wraps to zero on the last sample of the window.
                        sample_cnt <= sample_cnt + WINDOW_LOG2'(1);
                        if (&sample_cnt)
                            state <= CALC;
                    end
                end
                // stage p1: signed window difference and direction
                CALC: begin
                    diff_p1 <= diff_c;
                    dir_p1  <= (diff_c > 0);
                    state   <= SCALE;
                end
                // stage p2: per-sample average, gain, saturation, deadband
                SCALE: begin
                    val_p2 <= val_c;
                    if (int'(val_c) < DEADBAND) begin
                        state      <= ACCUM;
                        acc_l      <= '0;
                        acc_r      <= '0;
                        sample_cnt <= '0;
                    end else begin
                        state <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (servo_ready) begin
                        state     <= EMIT;
                        audio_dir <= dir_p1;
                        audio_val <= val_p2;
                    end
                end
                EMIT: begin
                    state      <= ACCUM;
                    acc_l      <= '0;
                    acc_r      <= '0;
                    sample_cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
